system_0_sysid_checker: RTL and testbench
=========================================

# system_0_sysid_checker

Avalon-MM read initiator that interrogates the system ID peripheral after reset or on request. It reads the ID word (word address 0) and the timestamp word (word address 1) and compares both against build-time expected values. It reports pass, fail or timeout to the board's status logic (LEDs / HEX), so a stale or mismatched FPGA image is flagged before software runs.

## Interface
- EXPECTED_ID, 32'd0, value the ID word must equal
- EXPECTED_TIMESTAMP, 32'd1720111226 (32'h6686_D07A), value the timestamp word must equal
- TIMEOUT_CYCLES, 1024, maximum cycles per read transaction, counted from first `read` assertion until `readdatavalid`; range 2..65535
- AUTO_START, 1, when 1 a check starts automatically after reset release
- clock  in  1  single system clock; all logic rising-edge
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins a check when idle or done
- avm_address  out  1  word address to sysid slave
- avm_read  out  1  read request
- avm_waitrequest  in  1  slave stall; command accepted when `avm_read & !avm_waitrequest`
- avm_readdata  in  32  read data, valid when `avm_readdatavalid`
- avm_readdatavalid  in  1  read response strobe
- busy  out  1  check in progress
- done  out  1  check finished; level, held until next start or reset
- id_ok  out  1  captured ID equals EXPECTED_ID
- ts_ok  out  1  captured timestamp equals EXPECTED_TIMESTAMP
- timeout  out  1  a transaction exceeded TIMEOUT_CYCLES
- id_value  out  32  captured ID word
- ts_value  out  32  captured timestamp word

## Operation
- States: IDLE, CMD_ID, RSP_ID, CMD_TS, RSP_TS, DONE.
- IDLE: on `start`, or on the first cycle after reset if AUTO_START=1, go to CMD_ID. Clear id_ok, ts_ok, timeout, done and both captured values.
- CMD_ID: `avm_read=1`, `avm_address=0`. Read and address are held stable while `avm_waitrequest=1`. On acceptance go to RSP_ID.
- RSP_ID: `avm_read=0`. On `avm_readdatavalid`, latch `id_value`, set `id_ok=(readdata==EXPECTED_ID)`, go to CMD_TS.
- CMD_TS / RSP_TS: same as the ID states with `avm_address=1`. Latch `ts_value` and `ts_ok`, then go to DONE.
- Zero-latency responses: if `avm_readdatavalid` is asserted in the same cycle the command is accepted, capture the data in that cycle and skip the RSP state.
- Stray `avm_readdatavalid` in IDLE, CMD states with no accepted command, or DONE is ignored.
- Timeout: a 16-bit counter is cleared on entry to each CMD state and increments every cycle in CMD/RSP. When it reaches TIMEOUT_CYCLES: set `timeout=1`, drop `avm_read`, go to DONE. The remaining read is skipped and its `_ok` flag stays 0.
- DONE: `done=1`, `busy=0`. A `start` re-runs the check exactly as from IDLE.
- `start` while busy is ignored.
- Pass condition for downstream logic is `done & id_ok & ts_ok & !timeout`. The block does not compute it.

## Timing
- Reset values: `avm_read=0`, `avm_address=0`, `busy=0`, `done=0`, `id_ok=0`, `ts_ok=0`, `timeout=0`, `id_value=0`, `ts_value=0`. State returns to IDLE.
- Reset asserted mid-transaction aborts it immediately: `avm_read` is 0 on the cycle after reset is sampled. A late response after reset is ignored.
- `avm_read` asserts on the cycle after the start pulse (or after reset release for AUTO_START).
- All outputs are registered; no combinational path from Avalon inputs to outputs.
- Best case with zero wait states and zero latency: start at cycle 0, ID read at cycle 1, TS read at cycle 2, `done=1` at cycle 3.
- `busy` is high from the cycle after start until the cycle `done` rises.

## Structure
- Shared package `system_0_sysid_pkg` holds:
  - state enum typedef
  - address constants `SYSID_ADDR_ID=1'b0` and `SYSID_ADDR_TS=1'b1`
  - default expected values, reused by the sysid slave generator and testbench
- No sub-module. FSM, timeout counter and compare registers live in one module.

## Test plan
- Zero-wait, zero-latency slave returning 0 / 1720111226, AUTO_START=1 → `done` at cycle 3 after reset release, `id_ok=1`, `ts_ok=1`, `timeout=0`.
- Slave holds waitrequest 5 cycles and responds with latency 2 → `avm_read`/`avm_address` stable throughout, both reads correct, done at cycle 17.
- Slave returns timestamp 32'h6686_D07B → `ts_ok=0`, `id_ok=1`, `ts_value=32'h6686_D07B`.
- Slave never asserts readdatavalid for the ID read, TIMEOUT_CYCLES=16 → `timeout=1` after 16 cycles, `done=1`, `id_ok=0`, `ts_ok=0`, no TS read issued.
- Reset pulsed during RSP_TS, then a late readdatavalid arrives → outputs at reset values, late data ignored, and the check restarts if AUTO_START=1.
- `start` pulsed while busy, then again in DONE → first pulse ignored; second clears flags and repeats both reads.

Source files
------------

// File: rtl/system_0_sysid_pkg.sv
// Shared definitions for the system ID checker: FSM states, sysid word
// addresses and the default expected ID / timestamp values.
package system_0_sysid_pkg;

    localparam int unsigned SYSID_DATA_W = 32;
    localparam int unsigned SYSID_TMO_W  = 16;

    localparam logic SYSID_ADDR_ID = 1'b0;
    localparam logic SYSID_ADDR_TS = 1'b1;

    localparam logic [SYSID_DATA_W-1:0] SYSID_DEFAULT_ID        = 32'd0;
    localparam logic [SYSID_DATA_W-1:0] SYSID_DEFAULT_TIMESTAMP = 32'h6686_D07A;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD_ID,
        ST_RSP_ID,
        ST_CMD_TS,
        ST_RSP_TS,
        ST_DONE
    } sysid_state_e;

endpackage

// File: rtl/system_0_sysid_checker.sv
// Avalon-MM read initiator that fetches the sysid ID and timestamp words,
// compares them to build-time values and reports pass/fail/timeout.
module system_0_sysid_checker
    import system_0_sysid_pkg::*;
#(
    parameter logic [SYSID_DATA_W-1:0] EXPECTED_ID        = SYSID_DEFAULT_ID,
    parameter logic [SYSID_DATA_W-1:0] EXPECTED_TIMESTAMP = SYSID_DEFAULT_TIMESTAMP,
    parameter int unsigned             TIMEOUT_CYCLES     = 1024,
    parameter bit                      AUTO_START         = 1'b1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    output logic                    avm_address,
    output logic                    avm_read,
    input  logic                    avm_waitrequest,
    input  logic [SYSID_DATA_W-1:0] avm_readdata,
    input  logic                    avm_readdatavalid,
    output logic                    busy,
    output logic                    done,
    output logic                    id_ok,
    output logic                    ts_ok,
    output logic                    timeout,
    output logic [SYSID_DATA_W-1:0] id_value,
    output logic [SYSID_DATA_W-1:0] ts_value
);

    localparam logic [SYSID_TMO_W-1:0] TMO_LAST = SYSID_TMO_W'(TIMEOUT_CYCLES - 1);

    sysid_state_e             state_q, state_d;
    logic [SYSID_TMO_W-1:0]   cnt_q, cnt_d;
    logic                     auto_q, auto_d;
    logic                     read_q, read_d;
    logic                     addr_q, addr_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic                     id_ok_q, id_ok_d;
    logic                     ts_ok_q, ts_ok_d;
    logic                     tmo_q, tmo_d;
    logic [SYSID_DATA_W-1:0]  id_val_q, id_val_d;
    logic [SYSID_DATA_W-1:0]  ts_val_q, ts_val_d;
    logic                     accepted;
    logic                     tmo_hit;
    logic                     launch;

    assign accepted = read_q & ~avm_waitrequest;
    assign tmo_hit  = (cnt_q == TMO_LAST);

    // Next-state, capture and output decode; outputs follow the next state
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        auto_d   = 1'b0;
        id_ok_d  = id_ok_q;
        ts_ok_d  = ts_ok_q;
        tmo_d    = tmo_q;
        id_val_d = id_val_q;
        ts_val_d = ts_val_q;
        launch   = 1'b0;

        case (state_q)
            ST_IDLE: launch = start | auto_q;
            ST_CMD_ID, ST_RSP_ID: begin
                // Data only counts once our command has been accepted
                if (avm_readdatavalid && (accepted || state_q == ST_RSP_ID)) begin
                    id_val_d = avm_readdata;
                    id_ok_d  = (avm_readdata == EXPECTED_ID);
                    cnt_d    = '0;
                    state_d  = ST_CMD_TS;
                end else if (tmo_hit) begin
                    tmo_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + SYSID_TMO_W'(1);
                    if (state_q == ST_CMD_ID && accepted) begin
                        state_d = ST_RSP_ID;
                    end
                end
            end
            ST_CMD_TS, ST_RSP_TS: begin
                if (avm_readdatavalid && (accepted || state_q == ST_RSP_TS)) begin
                    ts_val_d = avm_readdata;
                    ts_ok_d  = (avm_readdata == EXPECTED_TIMESTAMP);
                    state_d  = ST_DONE;
                end else if (tmo_hit) begin
                    tmo_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + SYSID_TMO_W'(1);
                    if (state_q == ST_CMD_TS && accepted) begin
                        state_d = ST_RSP_TS;
                    end
                end
            end
            ST_DONE: launch = start;
            default: state_d = ST_IDLE;
        endcase

        if (launch) begin
            state_d  = ST_CMD_ID;
            cnt_d    = '0;
            id_ok_d  = 1'b0;
            ts_ok_d  = 1'b0;
            tmo_d    = 1'b0;
            id_val_d = '0;
            ts_val_d = '0;
        end

        read_d = (state_d == ST_CMD_ID) || (state_d == ST_CMD_TS);
        addr_d = (state_d == ST_CMD_TS) ? SYSID_ADDR_TS : SYSID_ADDR_ID;
        busy_d = (state_d != ST_IDLE) && (state_d != ST_DONE);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            auto_q   <= AUTO_START;
            read_q   <= 1'b0;
            addr_q   <= SYSID_ADDR_ID;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            id_ok_q  <= 1'b0;
            ts_ok_q  <= 1'b0;
            tmo_q    <= 1'b0;
            id_val_q <= '0;
            ts_val_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            auto_q   <= auto_d;
            read_q   <= read_d;
            addr_q   <= addr_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            id_ok_q  <= id_ok_d;
            ts_ok_q  <= ts_ok_d;
            tmo_q    <= tmo_d;
            id_val_q <= id_val_d;
            ts_val_q <= ts_val_d;
        end
    end

    assign avm_read    = read_q;
    assign avm_address = addr_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign id_ok       = id_ok_q;
    assign ts_ok       = ts_ok_q;
    assign timeout     = tmo_q;
    assign id_value    = id_val_q;
    assign ts_value    = ts_val_q;

endmodule

// File: tb/tb_system_0_sysid_checker.sv
// Bench for system_0_sysid_checker: configurable sysid slave model, vector
// table plus hand-written busy/restart/reset sequences, scoreboard on done.
module tb_system_0_sysid_checker;

    localparam logic [31:0] TB_ID  = 32'd0;
    localparam logic [31:0] TB_TS  = 32'd1720111226;
    localparam int          TB_TMO = 16;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        avm_address;
    logic        avm_read;
    logic        avm_waitrequest = 1'b0;
    logic [31:0] avm_readdata = 32'd0;
    logic        avm_readdatavalid = 1'b0;
    logic        busy, done, id_ok, ts_ok, timeout;
    logic [31:0] id_value, ts_value;

    system_0_sysid_checker #(
        .EXPECTED_ID        (TB_ID),
        .EXPECTED_TIMESTAMP (TB_TS),
        .TIMEOUT_CYCLES     (TB_TMO),
        .AUTO_START         (1'b1)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .start             (start),
        .avm_address       (avm_address),
        .avm_read          (avm_read),
        .avm_waitrequest   (avm_waitrequest),
        .avm_readdata      (avm_readdata),
        .avm_readdatavalid (avm_readdatavalid),
        .busy              (busy),
        .done              (done),
        .id_ok             (id_ok),
        .ts_ok             (ts_ok),
        .timeout           (timeout),
        .id_value          (id_value),
        .ts_value          (ts_value)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] id_data;
        logic [31:0] ts_data;
        int          wait_n;
        int          lat_n;
        bit          no_rsp;
        logic        exp_id_ok;
        logic        exp_ts_ok;
        logic        exp_tmo;
        logic [31:0] exp_id_val;
        logic [31:0] exp_ts_val;
        int          exp_ts_acc;
    } vec_t;

    typedef struct {
        logic [31:0] id_val;
        logic [31:0] ts_val;
        logic        id_ok;
        logic        ts_ok;
        logic        tmo;
        int          done_cyc;
    } sb_t;

    typedef struct {
        int          due;
        logic [31:0] data;
    } rsp_t;

    sb_t  sb_q[$];
    rsp_t pend[$];

    int          sl_wait = 0;
    int          sl_lat = 0;
    bit          sl_no_rsp = 1'b0;
    logic [31:0] sl_id = TB_ID;
    logic [31:0] sl_ts = TB_TS;
    int          n_id_acc = 0;
    int          n_ts_acc = 0;
    int          stab_err = 0;
    int          wcnt = 0;
    bit          prev_read = 1'b0;
    bit          prev_wait = 1'b0;
    logic        prev_addr = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    // Sysid slave: programmable wait states and read latency, checks stall stability
    always @(posedge clock) begin
        #1;
        if (prev_read && prev_wait && !(avm_read === 1'b1 && avm_address === prev_addr))
            stab_err++;
        if (avm_read === 1'b1) begin
            if (wcnt < sl_wait) begin
                avm_waitrequest = 1'b1;
                wcnt++;
            end else begin
                avm_waitrequest = 1'b0;
                wcnt = 0;
                if (avm_address === 1'b1) n_ts_acc++;
                else n_id_acc++;
                if (!sl_no_rsp)
                    pend.push_back('{cyc + sl_lat, (avm_address === 1'b1) ? sl_ts : sl_id});
            end
        end else begin
            avm_waitrequest = 1'b0;
            wcnt = 0;
        end
        avm_readdatavalid = 1'b0;
        avm_readdata      = 32'hDEAD_BEEF;
        if (pend.size() > 0 && pend[0].due == cyc) begin
            avm_readdatavalid = 1'b1;
            avm_readdata      = pend[0].data;
            void'(pend.pop_front());
        end
        prev_read = (avm_read === 1'b1);
        prev_wait = avm_waitrequest;
        prev_addr = avm_address;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Waits for done, checks busy profile and pops the expected result
    task automatic wait_done();
        sb_t e;
        int  n;
        bit  busy_bad;
        n = 0;
        busy_bad = 1'b0;
        while (done !== 1'b1 && n < 400) begin
            if (busy !== 1'b1) busy_bad = 1'b1;
            tick();
            n++;
        end
        chk("done_reached", 32'(done), 32'd1);
        chk("busy_while_running", 32'(busy_bad), 32'd0);
        chk("busy_at_done", 32'(busy), 32'd0);
        if (sb_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard: got done with empty queue, expected a pending check");
        end else begin
            e = sb_q.pop_front();
            chk("id_value", id_value, e.id_val);
            chk("ts_value", ts_value, e.ts_val);
            chk("id_ok", 32'(id_ok), 32'(e.id_ok));
            chk("ts_ok", 32'(ts_ok), 32'(e.ts_ok));
            chk("timeout", 32'(timeout), 32'(e.tmo));
            chk("done_cycle", 32'(cyc), 32'(e.done_cyc));
        end
    endtask

    vec_t vecs[5];
    int   s, d, id0, ts0, lat_total;

    initial begin
        vecs[0] = '{TB_ID, TB_TS, 0, 0, 1'b0, 1'b1, 1'b1, 1'b0, TB_ID, TB_TS, 1};
        vecs[1] = '{TB_ID, TB_TS, 5, 2, 1'b0, 1'b1, 1'b1, 1'b0, TB_ID, TB_TS, 1};
        vecs[2] = '{TB_ID, TB_TS, 0, 0, 1'b1, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0, 0};
        vecs[3] = '{TB_ID, 32'h6686_D07B, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0, TB_ID, 32'h6686_D07B, 1};
        vecs[4] = '{32'h0000_0005, TB_TS, 1, 1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0005, TB_TS, 1};

        // Reset values, then the automatic check after release
        repeat (3) @(posedge clock);
        #1;
        chk("rst_avm_read", 32'(avm_read), 32'd0);
        chk("rst_avm_address", 32'(avm_address), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_id_ok", 32'(id_ok), 32'd0);
        chk("rst_ts_ok", 32'(ts_ok), 32'd0);
        chk("rst_timeout", 32'(timeout), 32'd0);
        chk("rst_id_value", id_value, 32'd0);
        chk("rst_ts_value", ts_value, 32'd0);
        reset = 1'b0;
        sb_q.push_back('{TB_ID, TB_TS, 1'b1, 1'b1, 1'b0, cyc + 3});
        tick();
        chk("auto_read_issued", 32'({avm_read, avm_address}), 32'b10);
        wait_done();

        // Table-driven checks launched by start
        for (int i = 0; i < 5; i++) begin
            sl_id     = vecs[i].id_data;
            sl_ts     = vecs[i].ts_data;
            sl_wait   = vecs[i].wait_n;
            sl_lat    = vecs[i].lat_n;
            sl_no_rsp = vecs[i].no_rsp;
            id0 = n_id_acc;
            ts0 = n_ts_acc;
            lat_total = vecs[i].no_rsp ? (1 + TB_TMO)
                                       : (1 + 2 * (vecs[i].wait_n + vecs[i].lat_n + 1));
            s = cyc;
            start = 1'b1;
            sb_q.push_back('{vecs[i].exp_id_val, vecs[i].exp_ts_val, vecs[i].exp_id_ok,
                             vecs[i].exp_ts_ok, vecs[i].exp_tmo, s + lat_total});
            tick();
            start = 1'b0;
            wait_done();
            chk("id_reads", 32'(n_id_acc - id0), 32'd1);
            chk("ts_reads", 32'(n_ts_acc - ts0), 32'(vecs[i].exp_ts_acc));
        end

        // Start while busy is ignored; start in done reruns both reads
        sl_id = TB_ID; sl_ts = TB_TS; sl_wait = 5; sl_lat = 2; sl_no_rsp = 1'b0;
        id0 = n_id_acc;
        ts0 = n_ts_acc;
        s = cyc;
        start = 1'b1;
        sb_q.push_back('{TB_ID, TB_TS, 1'b1, 1'b1, 1'b0, s + 17});
        tick();
        start = 1'b0;
        repeat (4) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done();
        chk("busy_start_id_reads", 32'(n_id_acc - id0), 32'd1);
        repeat (4) tick();
        chk("done_held", 32'(done), 32'd1);
        d = cyc;
        start = 1'b1;
        sb_q.push_back('{TB_ID, TB_TS, 1'b1, 1'b1, 1'b0, d + 17});
        tick();
        start = 1'b0;
        chk("rerun_done_cleared", 32'(done), 32'd0);
        chk("rerun_ts_ok_cleared", 32'(ts_ok), 32'd0);
        chk("rerun_ts_value_cleared", ts_value, 32'd0);
        chk("rerun_read", 32'(avm_read), 32'd1);
        wait_done();
        chk("rerun_id_reads", 32'(n_id_acc - id0), 32'd2);
        chk("rerun_ts_reads", 32'(n_ts_acc - ts0), 32'd2);

        // Reset during the TS response; the late response lands in the restarted ID stall
        sl_wait = 2; sl_lat = 4;
        s = cyc;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (10) tick();
        chk("in_rsp_ts", 32'({avm_read, busy}), 32'b01);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_avm_read", 32'(avm_read), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_id_ok", 32'(id_ok), 32'd0);
        chk("mid_rst_id_value", id_value, 32'd0);
        ts0 = n_ts_acc;
        sb_q.push_back('{TB_ID, TB_TS, 1'b1, 1'b1, 1'b0, cyc + 15});
        tick();
        wait_done();
        chk("restart_ts_reads", 32'(n_ts_acc - ts0), 32'd1);

        chk("stall_stability_errors", 32'(stab_err), 32'd0);
        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
